// File: rtl/dma_mem_rsp_adapter.sv
// dma_mem_rsp_adapter
//   Sits between AXI-to-memory converters and the wide DMA superbank ports.
//   Each channel gates its requests on a response credit, follows every
//   granted access through a fixed-latency valid pipeline, and buffers the
//   returned data in a small FIFO so the requester can apply backpressure.
//
// Ports (per-channel ports are packed [NumChannels-1:0] arrays):
//   clk_i, rst_i           clock, asynchronous active-high reset
//   req_i / gnt_o          requester access request / accepted this cycle
//   addr_i, we_i,
//   wdata_i, strb_i        access attributes, passed straight to memory
//   rsp_valid_o/ready_i    response handshake towards the requester
//   rsp_rdata_o, rsp_we_o  response payload (rdata is zero for writes)
//   mem_req_o / mem_gnt_i  superbank request handshake
//   mem_addr_o, mem_we_o,
//   mem_wdata_o,mem_strb_o pass-through of the access attributes
//   mem_rdata_i            read data, valid MemLatency cycles after handshake
//   busy_o                 some channel still has responses outstanding
module dma_mem_rsp_adapter #(
  parameter int NumChannels = 1,
  parameter int AddrWidth   = 32,
  parameter int DataWidth   = 512,
  parameter int MemLatency  = 1,
  parameter int RspDepth    = 4,
  parameter bit FallThrough = 1'b0
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic [NumChannels-1:0]                    req_i,
  output logic [NumChannels-1:0]                    gnt_o,
  input  logic [NumChannels-1:0][AddrWidth-1:0]     addr_i,
  input  logic [NumChannels-1:0]                    we_i,
  input  logic [NumChannels-1:0][DataWidth-1:0]     wdata_i,
  input  logic [NumChannels-1:0][DataWidth/8-1:0]   strb_i,
  output logic [NumChannels-1:0]                    rsp_valid_o,
  input  logic [NumChannels-1:0]                    rsp_ready_i,
  output logic [NumChannels-1:0][DataWidth-1:0]     rsp_rdata_o,
  output logic [NumChannels-1:0]                    rsp_we_o,
  output logic [NumChannels-1:0]                    mem_req_o,
  input  logic [NumChannels-1:0]                    mem_gnt_i,
  output logic [NumChannels-1:0][AddrWidth-1:0]     mem_addr_o,
  output logic [NumChannels-1:0]                    mem_we_o,
  output logic [NumChannels-1:0][DataWidth-1:0]     mem_wdata_o,
  output logic [NumChannels-1:0][DataWidth/8-1:0]   mem_strb_o,
  input  logic [NumChannels-1:0][DataWidth-1:0]     mem_rdata_i,
  output logic                                      busy_o
);

  localparam int CntWidth = $clog2(RspDepth + 1);
  localparam int PtrWidth = (RspDepth > 1) ? $clog2(RspDepth) : 1;

  assign mem_addr_o  = addr_i;
  assign mem_we_o    = we_i;
  assign mem_wdata_o = wdata_i;
  assign mem_strb_o  = strb_i;

  logic [NumChannels-1:0] busy;
  assign busy_o = |busy;

  for (genvar c = 0; c < NumChannels; c++) begin : g_chan
    logic [CntWidth-1:0]  cnt;
    logic                 handshake;
    logic                 pop;
    logic [MemLatency-1:0] pipe_valid;
    logic [MemLatency-1:0] pipe_we;
    logic                 capture;
    logic                 cap_we;
    logic [DataWidth-1:0] cap_data;
    logic [DataWidth-1:0] fifo_data [RspDepth];
    logic [RspDepth-1:0]  fifo_we;
    logic [PtrWidth-1:0]  wr_ptr;
    logic [PtrWidth-1:0]  rd_ptr;
    logic [CntWidth-1:0]  fifo_cnt;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 bypass;
    logic                 push;
    logic                 fifo_pop;
    logic                 rsp_valid;
    logic                 rsp_we;
    logic [DataWidth-1:0] rsp_rdata;

    // A credit is only returned on the clock edge after a pop, so a full
    // channel cannot re-issue in the same cycle it hands out a response.
    // Requests are held off during reset so no grant can be lost.
    assign mem_req_o[c] = req_i[c] & (cnt < CntWidth'(RspDepth)) & ~rst_i;
    assign handshake    = mem_req_o[c] & mem_gnt_i[c];
    assign gnt_o[c]     = handshake;
    assign busy[c]      = (cnt != '0);

    // Valid/we shift register modelling the fixed memory read latency.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        pipe_valid <= '0;
        pipe_we    <= '0;
      end else begin
        pipe_valid[0] <= handshake;
        pipe_we[0]    <= we_i[c];
        for (int k = 1; k < MemLatency; k++) begin
          pipe_valid[k] <= pipe_valid[k-1];
          pipe_we[k]    <= pipe_we[k-1];
        end
      end
    end

    assign capture  = pipe_valid[MemLatency-1];
    assign cap_we   = pipe_we[MemLatency-1];
    assign cap_data = cap_we ? '0 : mem_rdata_i[c];

    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == CntWidth'(RspDepth));
    assign bypass     = FallThrough && fifo_empty && capture;

    // Response mux: the captured beat when falling through an empty FIFO,
    // otherwise the FIFO head. Payload is forced to zero while idle.
    always_comb begin
      rsp_valid = 1'b0;
      rsp_we    = 1'b0;
      rsp_rdata = '0;
      if (bypass) begin
        rsp_valid = 1'b1;
        rsp_we    = cap_we;
        rsp_rdata = cap_data;
      end else if (!fifo_empty) begin
        rsp_valid = 1'b1;
        rsp_we    = fifo_we[rd_ptr];
        rsp_rdata = fifo_data[rd_ptr];
      end
    end

    assign rsp_valid_o[c] = rsp_valid;
    assign rsp_we_o[c]    = rsp_we;
    assign rsp_rdata_o[c] = rsp_rdata;

    // A fall-through beat consumed in its capture cycle never enters the FIFO.
    assign pop      = rsp_valid & rsp_ready_i[c];
    assign push     = capture & ~(bypass & rsp_ready_i[c]);
    assign fifo_pop = pop & ~fifo_empty;

    // FIFO pointers, occupancy and the channel credit counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        fifo_cnt <= '0;
        cnt      <= '0;
      end else begin
        if (push) begin
          wr_ptr <= (wr_ptr == PtrWidth'(RspDepth - 1)) ? '0 : wr_ptr + 1'b1;
        end
        if (fifo_pop) begin
          rd_ptr <= (rd_ptr == PtrWidth'(RspDepth - 1)) ? '0 : rd_ptr + 1'b1;
        end
        fifo_cnt <= fifo_cnt + CntWidth'(push) - CntWidth'(fifo_pop);
        cnt      <= cnt + CntWidth'(handshake) - CntWidth'(pop);
      end
    end

    // Storage needs no reset: entries are only read below the write pointer.
    always_ff @(posedge clk_i) begin
      if (push) begin
        fifo_data[wr_ptr] <= cap_data;
        fifo_we[wr_ptr]   <= cap_we;
      end
    end

    // The credit scheme must make an overflowing push impossible.
    no_overflow: assert property (@(posedge clk_i) disable iff (rst_i) !(push && fifo_full));
  end

endmodule

// File: tb/tb_dma_mem_rsp_adapter.sv
// Testbench for dma_mem_rsp_adapter.
//   Four requester lanes across three instances:
//     lane 0 : u_base  (defaults: MemLatency 1, RspDepth 4, no fall-through)
//     lane 1 : u_ft    (defaults with fall-through)
//     lane 2,3 : u_multi (2 channels, MemLatency 3, RspDepth 4, fall-through)
//   A memory model returns data exactly MemLatency cycles after each
//   handshake; a reference model keeps per-lane queues of granted accesses
//   and derives grant, credit, response timing/order/payload and busy.
module tb_dma_mem_rsp_adapter;

  localparam int NL    = 4;
  localparam int AW    = 32;
  localparam int DW    = 512;
  localparam int SW    = DW / 8;
  localparam int Depth = 4;

  logic clk;
  logic rst;
  logic [NL-1:0]         req, we, rsp_ready, mem_gnt;
  logic [NL-1:0][AW-1:0] addr;
  logic [NL-1:0][DW-1:0] wdata, mem_rdata;
  logic [NL-1:0][SW-1:0] strb;
  wire  [NL-1:0]         gnt, rsp_valid, rsp_we, mem_req, mem_we;
  wire  [NL-1:0][AW-1:0] mem_addr;
  wire  [NL-1:0][DW-1:0] rsp_rdata, mem_wdata;
  wire  [NL-1:0][SW-1:0] mem_strb;
  wire                   busy_base, busy_ft, busy_multi;

  int lat [NL] = '{1, 1, 3, 3};
  bit ftl [NL] = '{1'b0, 1'b1, 1'b1, 1'b1};

  typedef struct {
    logic [DW-1:0] data;
    logic          we;
    int            t;
  } exp_t;

  exp_t          expq [NL][$];
  int            head_since [NL];
  int            cycle;
  logic [DW-1:0] sched_data [NL][8];
  int            sched_cyc  [NL][8];
  bit            use_fixed  [NL];
  logic [DW-1:0] fixed_data [NL];
  int            n_cmp;
  int            n_fail;

  dma_mem_rsp_adapter #(.NumChannels(1)) u_base (
    .clk_i(clk), .rst_i(rst), .req_i(req[0:0]), .gnt_o(gnt[0:0]), .addr_i(addr[0:0]),
    .we_i(we[0:0]), .wdata_i(wdata[0:0]), .strb_i(strb[0:0]), .rsp_valid_o(rsp_valid[0:0]),
    .rsp_ready_i(rsp_ready[0:0]), .rsp_rdata_o(rsp_rdata[0:0]), .rsp_we_o(rsp_we[0:0]),
    .mem_req_o(mem_req[0:0]), .mem_gnt_i(mem_gnt[0:0]), .mem_addr_o(mem_addr[0:0]),
    .mem_we_o(mem_we[0:0]), .mem_wdata_o(mem_wdata[0:0]), .mem_strb_o(mem_strb[0:0]),
    .mem_rdata_i(mem_rdata[0:0]), .busy_o(busy_base));

  dma_mem_rsp_adapter #(.NumChannels(1), .FallThrough(1'b1)) u_ft (
    .clk_i(clk), .rst_i(rst), .req_i(req[1:1]), .gnt_o(gnt[1:1]), .addr_i(addr[1:1]),
    .we_i(we[1:1]), .wdata_i(wdata[1:1]), .strb_i(strb[1:1]), .rsp_valid_o(rsp_valid[1:1]),
    .rsp_ready_i(rsp_ready[1:1]), .rsp_rdata_o(rsp_rdata[1:1]), .rsp_we_o(rsp_we[1:1]),
    .mem_req_o(mem_req[1:1]), .mem_gnt_i(mem_gnt[1:1]), .mem_addr_o(mem_addr[1:1]),
    .mem_we_o(mem_we[1:1]), .mem_wdata_o(mem_wdata[1:1]), .mem_strb_o(mem_strb[1:1]),
    .mem_rdata_i(mem_rdata[1:1]), .busy_o(busy_ft));

  dma_mem_rsp_adapter #(.NumChannels(2), .MemLatency(3), .RspDepth(4), .FallThrough(1'b1)) u_multi (
    .clk_i(clk), .rst_i(rst), .req_i(req[3:2]), .gnt_o(gnt[3:2]), .addr_i(addr[3:2]),
    .we_i(we[3:2]), .wdata_i(wdata[3:2]), .strb_i(strb[3:2]), .rsp_valid_o(rsp_valid[3:2]),
    .rsp_ready_i(rsp_ready[3:2]), .rsp_rdata_o(rsp_rdata[3:2]), .rsp_we_o(rsp_we[3:2]),
    .mem_req_o(mem_req[3:2]), .mem_gnt_i(mem_gnt[3:2]), .mem_addr_o(mem_addr[3:2]),
    .mem_we_o(mem_we[3:2]), .mem_wdata_o(mem_wdata[3:2]), .mem_strb_o(mem_strb[3:2]),
    .mem_rdata_i(mem_rdata[3:2]), .busy_o(busy_multi));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // Memory side: scheduled read data in its return cycle, garbage otherwise.
  initial begin : memory_model
    cycle     = 0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      cycle++;
      #1;
      for (int l = 0; l < NL; l++) begin
        if (sched_cyc[l][cycle % 8] == cycle) mem_rdata[l] = sched_data[l][cycle % 8];
        else mem_rdata[l] = rand_data();
      end
    end
  end

  // Reference model and scoreboard, evaluated mid-cycle on every cycle.
  bit            m_req, m_hs, m_valid, m_busy;
  int            m_ready, m_slot;
  exp_t          m_front, m_new;
  logic [DW-1:0] m_data;

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int l = 0; l < NL; l++) begin
          expq[l].delete();
          head_since[l] = cycle;
        end
      end else begin
        m_busy = expq[0].size() != 0;
        n_cmp++;
        if (busy_base !== m_busy) begin n_fail++; $display("[TB] FAIL busy_base cyc %0d: got %b want %b", cycle, busy_base, m_busy); end
        m_busy = expq[1].size() != 0;
        n_cmp++;
        if (busy_ft !== m_busy) begin n_fail++; $display("[TB] FAIL busy_ft cyc %0d: got %b want %b", cycle, busy_ft, m_busy); end
        m_busy = (expq[2].size() + expq[3].size()) != 0;
        n_cmp++;
        if (busy_multi !== m_busy) begin n_fail++; $display("[TB] FAIL busy_multi cyc %0d: got %b want %b", cycle, busy_multi, m_busy); end

        for (int l = 0; l < NL; l++) begin
          m_req = req[l] && (expq[l].size() < Depth);
          m_hs  = m_req && mem_gnt[l];
          n_cmp++;
          if (mem_req[l] !== m_req) begin n_fail++; $display("[TB] FAIL mem_req lane %0d cyc %0d: got %b want %b", l, cycle, mem_req[l], m_req); end
          n_cmp++;
          if (gnt[l] !== m_hs) begin n_fail++; $display("[TB] FAIL gnt lane %0d cyc %0d: got %b want %b", l, cycle, gnt[l], m_hs); end

          m_valid = 1'b0;
          if (expq[l].size() > 0) begin
            m_front = expq[l][0];
            m_ready = m_front.t + lat[l] + 1;
            if (ftl[l] && head_since[l] <= m_front.t + lat[l]) m_ready = m_front.t + lat[l];
            m_valid = (cycle >= m_ready);
          end
          n_cmp++;
          if (rsp_valid[l] !== m_valid) begin n_fail++; $display("[TB] FAIL rsp_valid lane %0d cyc %0d: got %b want %b", l, cycle, rsp_valid[l], m_valid); end
          if (m_valid) begin
            n_cmp++;
            if (rsp_rdata[l] !== m_front.data) begin n_fail++; $display("[TB] FAIL rsp_rdata lane %0d cyc %0d: got %h want %h", l, cycle, rsp_rdata[l], m_front.data); end
            n_cmp++;
            if (rsp_we[l] !== m_front.we) begin n_fail++; $display("[TB] FAIL rsp_we lane %0d cyc %0d: got %b want %b", l, cycle, rsp_we[l], m_front.we); end
            if (rsp_ready[l]) begin
              void'(expq[l].pop_front());
              head_since[l] = cycle + 1;
            end
          end

          if (m_hs) begin
            m_data = use_fixed[l] ? fixed_data[l] : rand_data();
            use_fixed[l] = 1'b0;
            m_slot = (cycle + lat[l]) % 8;
            sched_data[l][m_slot] = m_data;
            sched_cyc[l][m_slot]  = cycle + lat[l];
            if (expq[l].size() == 0) head_since[l] = cycle;
            m_new.data = we[l] ? '0 : m_data;
            m_new.we   = we[l];
            m_new.t    = cycle;
            expq[l].push_back(m_new);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req       = '0;
    we        = '0;
    mem_gnt   = '0;
    rsp_ready = '0;
    for (int l = 0; l < NL; l++) begin
      addr[l]  = $urandom();
      wdata[l] = rand_data();
      strb[l]  = {$urandom(), $urandom()};
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int l = 0; l < NL; l++) begin
      n_cmp++;
      if ({gnt[l], rsp_valid[l], rsp_we[l], mem_req[l]} !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_ctrl lane %0d: got %b want 0000", l, {gnt[l], rsp_valid[l], rsp_we[l], mem_req[l]}); end
      n_cmp++;
      if (rsp_rdata[l] !== '0) begin n_fail++; $display("[TB] FAIL reset_rdata lane %0d: got %h want 0", l, rsp_rdata[l]); end
      n_cmp++;
      if (mem_addr[l] !== addr[l] || mem_wdata[l] !== wdata[l] || mem_strb[l] !== strb[l] || mem_we[l] !== we[l]) begin
        n_fail++; $display("[TB] FAIL passthrough lane %0d: got addr %h want %h", l, mem_addr[l], addr[l]);
      end
    end
    n_cmp++;
    if ({busy_base, busy_ft, busy_multi} !== 3'b000) begin n_fail++; $display("[TB] FAIL reset_busy: got %b want 000", {busy_base, busy_ft, busy_multi}); end
    tick();
    rst       = 1'b0;
    rsp_ready = '1;
    mem_gnt   = '1;
  endtask

  task automatic test_single_read();
    tick();
    for (int l = 0; l < 2; l++) begin
      req[l]        = 1'b1;
      we[l]         = 1'b0;
      addr[l]       = 32'h40;
      use_fixed[l]  = 1'b1;
      fixed_data[l] = {64{8'hA5}};
    end
    @(negedge clk);
    n_cmp++;
    if (gnt[1:0] !== 2'b11) begin n_fail++; $display("[TB] FAIL single_gnt: got %b want 11", gnt[1:0]); end
    tick();
    req[1:0] = 2'b00;
    @(negedge clk);
    n_cmp++;
    if (rsp_valid[1:0] !== 2'b10) begin n_fail++; $display("[TB] FAIL single_t1_valid: got %b want 10", rsp_valid[1:0]); end
    n_cmp++;
    if (rsp_rdata[1] !== {64{8'hA5}} || rsp_we[1] !== 1'b0) begin n_fail++; $display("[TB] FAIL single_ft_data: got %h/%b want a5../0", rsp_rdata[1], rsp_we[1]); end
    tick();
    @(negedge clk);
    n_cmp++;
    if (rsp_valid[1:0] !== 2'b01) begin n_fail++; $display("[TB] FAIL single_t2_valid: got %b want 01", rsp_valid[1:0]); end
    n_cmp++;
    if (rsp_rdata[0] !== {64{8'hA5}} || rsp_we[0] !== 1'b0) begin n_fail++; $display("[TB] FAIL single_data: got %h/%b want a5../0", rsp_rdata[0], rsp_we[0]); end
    tick();
    @(negedge clk);
    n_cmp++;
    if (rsp_valid[1:0] !== 2'b00) begin n_fail++; $display("[TB] FAIL single_t3_valid: got %b want 00", rsp_valid[1:0]); end
  endtask

  task automatic test_backpressure();
    int grants;
    int n;
    grants = 0;
    tick();
    rsp_ready[2] = 1'b0;
    req[2]       = 1'b1;
    we[2]        = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (gnt[2]) grants++;
      if (i >= 5) begin
        n_cmp++;
        if (mem_req[2] !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_mem_req cycle %0d: got %b want 0", i, mem_req[2]); end
      end
      tick();
    end
    n_cmp++;
    if (grants != 4) begin n_fail++; $display("[TB] FAIL bp_grants: got %0d want 4", grants); end
    rsp_ready[2] = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (rsp_valid[2] !== 1'b1 || gnt[2] !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_first_pop: got valid %b gnt %b want 1 0", rsp_valid[2], gnt[2]); end
    tick();
    @(negedge clk);
    n_cmp++;
    if (gnt[2] !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_regrant: got %b want 1", gnt[2]); end
    tick();
    req[2] = 1'b0;
    n = 0;
    while (busy_multi !== 1'b0 && n < 40) begin tick(); n++; end
    n_cmp++;
    if (busy_multi !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_drain: got busy %b want 0", busy_multi); end
  endtask

  task automatic test_full_random();
    int n;
    for (int i = 0; i < 100; i++) begin
      tick();
      for (int l = 2; l < NL; l++) begin
        req[l]       = ($urandom_range(0, 4) != 0);
        we[l]        = $urandom_range(0, 1);
        mem_gnt[l]   = ($urandom_range(0, 3) != 0);
        rsp_ready[l] = ($urandom_range(0, 2) == 0);
        addr[l]      = $urandom();
      end
    end
    tick();
    req[3:2]       = 2'b00;
    rsp_ready[3:2] = 2'b11;
    mem_gnt[3:2]   = 2'b11;
    n = 0;
    while (busy_multi !== 1'b0 && n < 40) begin tick(); n++; end
    n_cmp++;
    if (busy_multi !== 1'b0) begin n_fail++; $display("[TB] FAIL full_drain: got busy %b want 0", busy_multi); end
  endtask

  task automatic test_write_mixed();
    int n;
    tick();
    req[0]   = 1'b1;
    we[0]    = 1'b1;
    strb[0]  = '1;
    wdata[0] = rand_data();
    @(negedge clk);
    n_cmp++;
    if (gnt[0] !== 1'b1 || mem_we[0] !== 1'b1 || mem_strb[0] !== {SW{1'b1}}) begin n_fail++; $display("[TB] FAIL wr_issue: got gnt %b we %b want 1 1", gnt[0], mem_we[0]); end
    tick();
    req[0] = 1'b0;
    we[0]  = 1'b0;
    @(negedge clk);
    tick();
    @(negedge clk);
    n_cmp++;
    if (rsp_valid[0] !== 1'b1 || rsp_we[0] !== 1'b1 || rsp_rdata[0] !== '0) begin
      n_fail++; $display("[TB] FAIL wr_rsp: got valid %b we %b rdata %h want 1 1 0", rsp_valid[0], rsp_we[0], rsp_rdata[0]);
    end
    for (int i = 0; i < 40; i++) begin
      tick();
      for (int l = 0; l < 2; l++) begin
        req[l]       = $urandom_range(0, 1);
        we[l]        = $urandom_range(0, 1);
        wdata[l]     = rand_data();
        mem_gnt[l]   = ($urandom_range(0, 3) != 0);
        rsp_ready[l] = ($urandom_range(0, 3) != 0);
      end
    end
    tick();
    req[1:0]       = 2'b00;
    rsp_ready[1:0] = 2'b11;
    mem_gnt[1:0]   = 2'b11;
    n = 0;
    while ((busy_base | busy_ft) !== 1'b0 && n < 40) begin tick(); n++; end
    n_cmp++;
    if ((busy_base | busy_ft) !== 1'b0) begin n_fail++; $display("[TB] FAIL mixed_drain: got busy %b%b want 00", busy_base, busy_ft); end
  endtask

  task automatic test_multi_channel();
    int g2, g3, n;
    g2 = 0;
    g3 = 0;
    tick();
    req[3:2]       = 2'b11;
    we[3:2]        = 2'b00;
    rsp_ready[3:2] = 2'b10;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (gnt[2]) g2++;
      if (gnt[3]) g3++;
      if (i >= 2) begin
        n_cmp++;
        if (busy_multi !== 1'b1) begin n_fail++; $display("[TB] FAIL multi_busy cycle %0d: got %b want 1", i, busy_multi); end
      end
      tick();
    end
    n_cmp++;
    if (g3 != 20) begin n_fail++; $display("[TB] FAIL multi_throughput: got %0d grants want 20", g3); end
    n_cmp++;
    if (g2 != 4) begin n_fail++; $display("[TB] FAIL multi_stalled: got %0d grants want 4", g2); end
    req[3:2]       = 2'b00;
    rsp_ready[3:2] = 2'b11;
    n = 0;
    while (busy_multi !== 1'b0 && n < 40) begin tick(); n++; end
    n_cmp++;
    if (busy_multi !== 1'b0) begin n_fail++; $display("[TB] FAIL multi_drain: got busy %b want 0", busy_multi); end
  endtask

  task automatic test_reset_inflight();
    tick();
    req[2]       = 1'b1;
    we[2]        = 1'b0;
    rsp_ready[2] = 1'b1;
    repeat (2) tick();
    tick();
    req[2] = 1'b0;
    rst    = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({gnt[2], rsp_valid[2], rsp_we[2], mem_req[2], busy_multi} !== 5'b00000 || rsp_rdata[2] !== '0) begin
      n_fail++; $display("[TB] FAIL rst_mid: got %b want 00000", {gnt[2], rsp_valid[2], rsp_we[2], mem_req[2], busy_multi});
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_cmp++;
      if (rsp_valid[2] !== 1'b0 || busy_multi !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_stale cycle %0d: got valid %b busy %b want 0 0", i, rsp_valid[2], busy_multi); end
      tick();
    end
    req[2] = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (gnt[2] !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_regrant: got %b want 1", gnt[2]); end
    tick();
    req[2] = 1'b0;
    repeat (6) tick();
  endtask

  initial begin : watchdog
    #400000;
    n_fail++;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    n_cmp     = 0;
    n_fail    = 0;
    rst       = 1'b1;
    req       = '0;
    we        = '0;
    rsp_ready = '0;
    mem_gnt   = '0;
    addr      = '0;
    wdata     = '0;
    strb      = '0;
    for (int l = 0; l < NL; l++) begin
      use_fixed[l]  = 1'b0;
      head_since[l] = 0;
      for (int s = 0; s < 8; s++) sched_cyc[l][s] = -1;
    end
    test_reset();
    test_single_read();
    test_backpressure();
    test_full_random();
    test_write_mixed();
    test_multi_channel();
    test_reset_inflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
